// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Latency: a byte accepted into an empty, idle block drives its start bit from the next rising edge.
// Backpressure: in_ready drops while FIFO_DEPTH bytes are buffered; writes offered while full are dropped and set overflow.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   in_data/in_valid      byte write side, accepted when in_valid && in_ready
//   in_ready              FIFO has room (registered state only)
//   serial_tx             registered UART line, idle high, LSB first
//   busy                  frame on the line or bytes buffered
//   fifo_count            bytes currently buffered
//   send_count            completed frames since reset (wraps)
//   overflow              sticky: a write was offered while full
//
// Optional feature macro: UART_TX_PARITY_EN inserts an even parity bit between the data and stop bits.

// Generic synchronous FIFO with combinational head read; count and pointers are registered.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module uart_tx_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Storage is not reset: an empty count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the count unchanged.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
endmodule

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          serial_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   send_count,
  output logic                          overflow
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic [15:0]      r_send_cnt;
  logic             r_ovf;
  logic             r_rdy_en;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;

  // r_rdy_en holds in_ready low during reset and lets it rise on the first edge after release.
  assign w_full    = (w_count == DEPTH_C);
  assign in_ready  = r_rdy_en && !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (r_baud == BIT_LAST);
  // Pops depend only on registered state, so in_ready never sees them combinationally.
  assign w_pop     = (w_count != '0) &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  uart_tx_fifo_buf #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (in_data),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (in_valid && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_send_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) || w_bit_end) r_baud <= '0;
      else                                  r_baud <= r_baud + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              // r_shift[1] is the next data bit before this shift takes effect.
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_send_cnt <= r_send_cnt + 16'd1;
            // Chain straight into the next start bit when more data is waiting.
            if (w_pop) begin
              r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_head;
`endif
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign serial_tx  = r_tx;
  assign busy       = (r_state != S_IDLE) || (w_count != '0);
  assign fifo_count = w_count;
  assign send_count = r_send_cnt;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 16;
  localparam int CPB      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        serial_tx;
  logic        busy;
  logic [4:0]  fifo_count;
  logic [15:0] send_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .serial_tx  (serial_tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .send_count (send_count),
    .overflow   (overflow)
  );

  function automatic logic [NB-1:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits up to max_wait cycles for a start bit, then samples one whole frame.
  // waited = cycles spent waiting (-1 on timeout); glitch counts samples that differ
  // from the first sample of their bit period. Returns positioned on the cycle after the frame.
  task automatic grab_frame(input int max_wait, output int waited,
                            output logic [NB-1:0] bits, output int glitch);
    logic first;
    logic s;
    waited = 0;
    bits   = '0;
    glitch = 0;
    first  = 1'b1;
    while (serial_tx !== 1'b0 && waited < max_wait) begin
      step();
      waited++;
    end
    if (serial_tx !== 1'b0) begin
      waited = -1;
      return;
    end
    for (int c = 0; c < NB * CPB; c++) begin
      s = serial_tx;
      if (c % CPB == 0) first = s;
      else if (s !== first) glitch++;
      if (c % CPB == CPB / 2) bits[c / CPB] = s;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", serial_tx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    checks++; if (send_count !== 16'd0) begin errors++; $display("FAIL reset_send_count: got %0d want 0", send_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready_first_edge: got %b want 1", in_ready); end
  endtask

  task automatic test_single_byte();
    int w;
    int g;
    logic [NB-1:0] b;
    in_data = 8'h55;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count_after_push: got %0d want 1", fifo_count); end
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL single_tx_push_edge: got %b want 1", serial_tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    step();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d want 0", fifo_count); end
    grab_frame(0, w, b, g);
    checks++; if (w !== 0) begin errors++; $display("FAIL single_start_latency: waited %0d want 0", w); end
    checks++; if (b !== exp_frame(8'h55)) begin errors++; $display("FAIL single_frame: got %b want %b", b, exp_frame(8'h55)); end
    checks++; if (g !== 0) begin errors++; $display("FAIL single_bit_timing: glitches %0d want 0", g); end
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL single_idle_line: got %b want 1", serial_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    checks++; if (send_count !== 16'd1) begin errors++; $display("FAIL single_send_count: got %0d want 1", send_count); end
  endtask

  task automatic test_burst();
    int peak = 0;
    int stalls = 0;
    int gaps = 0;
    int bad = 0;
    int glitches = 0;
    int first_w = 0;
    int w;
    int g;
    logic [NB-1:0] b;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          in_data = 8'(i);
          in_valid = 1'b1;
          if (in_ready !== 1'b1) stalls++;
          step();
          if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          grab_frame((i == 0) ? 4 : 0, w, b, g);
          if (i == 0) first_w = w;
          else if (w != 0) gaps++;
          if (b !== exp_frame(8'(i))) bad++;
          glitches += g;
        end
      end
    join
    checks++; if (stalls !== 0) begin errors++; $display("FAIL burst_stalls: got %0d want 0", stalls); end
    checks++; if (peak !== 15) begin errors++; $display("FAIL burst_peak_count: got %0d want 15", peak); end
    checks++; if (first_w !== 2) begin errors++; $display("FAIL burst_first_start: waited %0d want 2", first_w); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL burst_gaps: got %0d want 0", gaps); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL burst_data_order: bad frames %0d want 0", bad); end
    checks++; if (glitches !== 0) begin errors++; $display("FAIL burst_bit_timing: glitches %0d want 0", glitches); end
    checks++; if (send_count !== 16'd17) begin errors++; $display("FAIL burst_send_count: got %0d want 17", send_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int gaps = 0;
    int bad = 0;
    int lows = 0;
    int w;
    int g;
    logic [NB-1:0] b;
    logic rdy17 = 1'b1;
    logic ovf_before = 1'b1;
    in_data = 8'hA0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL ovf_pre_count: got %0d want 0", fifo_count); end
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          in_data = 8'(8'hB0 + i);
          in_valid = 1'b1;
          if (i == 16) begin
            rdy17 = in_ready;
            ovf_before = overflow;
          end
          step();
        end
        in_valid = 1'b0;
        checks++; if (rdy17 !== 1'b0) begin errors++; $display("FAIL ovf_ready_when_full: got %b want 0", rdy17); end
        checks++; if (ovf_before !== 1'b0) begin errors++; $display("FAIL ovf_flag_early: got %b want 0", ovf_before); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_set: got %b want 1", overflow); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count_full: got %0d want 16", fifo_count); end
      end
      begin
        for (int i = 0; i < 17; i++) begin
          grab_frame(0, w, b, g);
          if (w != 0) gaps++;
          if (b !== exp_frame((i == 0) ? 8'hA0 : 8'(8'hB0 + i - 1))) bad++;
          if (g != 0) bad++;
        end
      end
    join
    checks++; if (gaps !== 0) begin errors++; $display("FAIL ovf_gaps: got %0d want 0", gaps); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_frames: bad %0d want 0", bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_after: got %b want 0", busy); end
    repeat (3 * CPB) begin
      step();
      if (serial_tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL ovf_extra_frame: low samples %0d want 0", lows); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (send_count !== 16'd34) begin errors++; $display("FAIL ovf_send_count: got %0d want 34", send_count); end
  endtask

  task automatic test_push_pop();
    int gaps = 0;
    int bad = 0;
    int first_w = 0;
    int w;
    int g;
    logic [NB-1:0] b;
    logic [7:0] exp_d [3] = '{8'h3C, 8'hC3, 8'h5A};
    fork
      begin
        in_data = 8'h3C;
        in_valid = 1'b1;
        step();
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL pp_count_push: got %0d want 1", fifo_count); end
        in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL pp_count_idle_pop: got %0d want 1", fifo_count); end
        checks++; if (serial_tx !== 1'b0) begin errors++; $display("FAIL pp_start: got %b want 0", serial_tx); end
        repeat (NB * CPB - 1) step();
        in_data = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL pp_count_stop_pop: got %0d want 1", fifo_count); end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          grab_frame((i == 0) ? 4 : 0, w, b, g);
          if (i == 0) first_w = w;
          else if (w != 0) gaps++;
          if (b !== exp_frame(exp_d[i])) bad++;
          if (g != 0) bad++;
        end
      end
    join
    checks++; if (first_w !== 2) begin errors++; $display("FAIL pp_first_start: waited %0d want 2", first_w); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL pp_gaps: got %0d want 0", gaps); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pp_order: bad %0d want 0", bad); end
    checks++; if (send_count !== 16'd37) begin errors++; $display("FAIL pp_send_count: got %0d want 37", send_count); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int w0;
    int w1;
    int g0;
    int g1;
    logic [NB-1:0] b0;
    logic [NB-1:0] b1;
    in_data = 8'h07;
    in_valid = 1'b1;
    step();
    in_data = 8'h03;
    step();
    in_valid = 1'b0;
    grab_frame(0, w0, b0, g0);
    grab_frame(0, w1, b1, g1);
    checks++; if (b0[9] !== 1'b1) begin errors++; $display("FAIL parity_07: got %b want 1", b0[9]); end
    checks++; if (b1[9] !== 1'b0) begin errors++; $display("FAIL parity_03: got %b want 0", b1[9]); end
    checks++; if (b0 !== 11'b1_1_00000111_0) begin errors++; $display("FAIL parity_frame_07: got %b", b0); end
    checks++; if (w1 !== 0 || g0 !== 0 || g1 !== 0) begin errors++; $display("FAIL parity_frame_length: wait %0d glitches %0d/%0d want 0", w1, g0, g1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_busy_after: got %b want 0", busy); end
    checks++; if (send_count !== 16'd39) begin errors++; $display("FAIL parity_send_count: got %0d want 39", send_count); end
  endtask
`endif

  task automatic test_mid_frame_reset();
    int lows = 0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mr_overflow_cleared: got %b want 0", overflow); end
    in_data = 8'hA5;
    in_valid = 1'b1;
    step();
    in_data = 8'h11;
    step();
    in_valid = 1'b0;
    // Now on the first start-bit cycle; move to the middle of data bit 3.
    repeat (CPB * 4 + CPB / 2) step();
    checks++; if (serial_tx !== 1'b0) begin errors++; $display("FAIL mr_bit3: got %b want 0", serial_tx); end
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL mr_count_before: got %0d want 1", fifo_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (serial_tx !== 1'b1) begin errors++; $display("FAIL mr_tx_forced: got %b want 1", serial_tx); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mr_count: got %0d want 0", fifo_count); end
    checks++; if (send_count !== 16'd0) begin errors++; $display("FAIL mr_send_count: got %0d want 0", send_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mr_in_ready: got %b want 0", in_ready); end
    step();
    step();
    rst_n = 1'b1;
    repeat (3 * NB * CPB) begin
      step();
      if (serial_tx !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL mr_no_frames: low samples %0d want 0", lows); end
    checks++; if (send_count !== 16'd0) begin errors++; $display("FAIL mr_send_count_after: got %0d want 0", send_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy_after: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_push_pop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_mid_frame_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, 2..256: transmit buffer depth in bytes.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_data  input  8  byte to transmit.
REQ-007 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 SHALL have port serial_tx  output  1  UART line, idle high, LSB first.
REQ-010 SHALL have port busy  output  1  a frame is on the line or the FIFO is non-empty.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
REQ-012 SHALL have port send_count  output  16  frames fully transmitted since reset, wraps 0xFFFF->0x0000.
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-014 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults) for every bit period, including start, data, parity and stop bits.
REQ-015 SHALL accept a byte on any rising edge where in_valid and in_ready are both high, and write it to the FIFO tail.
REQ-016 SHALL drive in_ready = (fifo_count != FIFO_DEPTH) from registered state only, with no combinational path from in_valid or the pop condition.
REQ-017 SHALL ignore in_valid while full, leave the FIFO contents unchanged, and set overflow to 1 until reset.
REQ-018 SHALL leave fifo_count unchanged when a push and a pop occur on the same edge.
REQ-019 SHALL implement the states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-029.
REQ-020 SHALL transition IDLE->START when fifo_count != 0, pop the head byte into a shift register, and drive serial_tx low on the same edge; a byte accepted at edge k into an empty idle block therefore starts the start bit at edge k+1.
REQ-021 SHALL shift in DATA for 8 bit periods, LSB first, then go to PARITY (if enabled) or STOP.
REQ-022 SHALL hold serial_tx high in STOP for one bit period; at its end SHALL increment send_count and go directly to START (no idle gap) if the FIFO is non-empty, else to IDLE.
REQ-023 SHALL register serial_tx, with no glitches between bit periods.
REQ-024 SHALL drive busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-025 SHALL, while rst_n is low, immediately force serial_tx=1, in_ready=0, busy=0, fifo_count=0, send_count=0, overflow=0, state=IDLE, and the bit and baud counters to 0.
REQ-026 SHALL discard any partial frame and all buffered bytes when reset asserts mid-frame; an aborted frame is not counted.
REQ-027 SHALL raise in_ready on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL use the macro UART_TX_PARITY_EN.
REQ-029 SHALL, with UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame of 11*CLKS_PER_BIT cycles.
REQ-030 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and logic entirely, giving a 10-bit 8N1 frame of 10*CLKS_PER_BIT cycles.

Verification
REQ-031 Write 0x55 once after reset -> serial_tx low from edge k+1 for 434 cycles, then bits 1,0,1,0,1,0,1,0 at 434 cycles each, then stop high; send_count=1; busy low after stop.
REQ-032 Burst 16 bytes 0x00..0x0F on consecutive cycles -> no stall; fifo_count peaks at 15 or 16; 16 back-to-back frames with no idle between stop and next start; bytes appear in order; send_count=16.
REQ-033 Write 17 bytes with in_valid held high while the first frame is in progress -> in_ready low while full, overflow=1, the extra byte is dropped, only 16 frames are sent.
REQ-034 Hold push and pop on the same edge with a non-empty FIFO -> fifo_count unchanged, data order preserved.
REQ-035 Pulse rst_n low during DATA bit 3 of 0xA5 -> serial_tx high immediately, fifo_count=0, send_count unchanged at 0, no further frames.
REQ-036 With UART_TX_PARITY_EN, send 0x07 -> parity bit=1 and frame length 4774 cycles; send 0x03 -> parity bit=0.
